register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
// - Parametrised register file for the core's decode/writeback stages: 2 combinational read ports, 1 write port.
// - Adds synchronous reset of all entries and optional write-to-read bypass.
// - Adds a per-register scoreboard: in-flight destinations are reserved at issue and released at writeback.
// - Decode uses the busy flags to stall on RAW hazards.
// PARAMETERS
// DATA_WIDTH  32  width of each register and data port
// ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH
// ZERO_REG    1   1: register 0 hardwired to zero, never written, never busy
// BYPASS      1   1: same-cycle write data/busy-clear forwarded to read ports
// PORTS
// clock_i            in   1             clock, all state on rising edge
// reset_i            in   1             synchronous, active-high reset
// rd_register_1_i    in   ADDR_WIDTH    read port 1 index
// rd_register_2_i    in   ADDR_WIDTH    read port 2 index
// rd_data_1_o        out  DATA_WIDTH    read port 1 data (combinational)
// rd_data_2_o        out  DATA_WIDTH    read port 2 data (combinational)
// rd_busy_1_o        out  1             read port 1 register has pending write
// rd_busy_2_o        out  1             read port 2 register has pending write
// reg_write_i        in   1             writeback strobe
// wr_register_i      in   ADDR_WIDTH    writeback index
// wr_data_i          in   DATA_WIDTH    writeback data
// issue_i            in   1             reserve issue_register_i as in-flight destination
// issue_register_i   in   ADDR_WIDTH    destination being reserved
// pending_count_o    out  ADDR_WIDTH+1  registered count of busy registers
// issue_conflict_o   out  1             1-cycle pulse: issue hit an already-busy register
// BEHAVIOUR
// - Reset (sync, dominates all other inputs in that cycle):
//   - all registers <= 0, all busy bits <= 0, pending_count_o <= 0, issue_conflict_o <= 0.
//   - Reads then return 0 and busy 0.
// - Write: on posedge with reg_write_i=1, registers[wr_register_i] <= wr_data_i.
//   - ZERO_REG=1 and index 0: write ignored.
// - Read: rd_data_N_o = registers[rd_register_N_i], combinational. ZERO_REG=1 and index 0: always 0.
// - Bypass, BYPASS=1 only. Condition: reg_write_i=1, wr_register_i == rd_register_N_i, index legal to write.
//   - rd_data_N_o = wr_data_i in the same cycle.
//   - rd_busy_N_o = 0 in the same cycle.
//   - BYPASS=0: old value and old busy bit until the next cycle.
// - Scoreboard:
//   - On posedge, issue_i=1 sets busy[issue_register_i]; reg_write_i=1 clears busy[wr_register_i].
//   - Index 0 with ZERO_REG=1 is never set.
//   - Issue and write to the same index in one cycle: set wins (new reservation after old writeback); busy stays 1.
//   - Issue and write to different indices: both take effect.
//   - Write to a non-busy register is legal: data stored, busy unchanged (0).
// - Conflict: issue_i=1 to a register already busy and not cleared that cycle.
//   - Sets issue_conflict_o=1 for exactly the next cycle.
//   - busy stays 1; count unchanged.
// - pending_count_o: registered; tracks popcount(busy) exactly.
//   - Same cycle: +1 if a 0->1 set occurs, -1 if a 1->0 clear occurs, 0 net for both/neither.
//   - Range 0..2**ADDR_WIDTH-(ZERO_REG); never wraps.
// - Latency: data write and busy changes are visible on the read ports the cycle after the edge (bypass aside).
// TESTING
// 1 write r5=0xDEADBEEF, issue r6; then reset_i=1 one cycle
//   -> rd r5=0x0, busy r6=0, pending_count_o=0, issue_conflict_o=0.
// 2 write r0=0xFFFFFFFF, issue r0 (ZERO_REG=1) -> rd r0=0x0, busy 0, pending_count_o stays 0.
// 3 reg_write_i=1 r3=0x12345678 with rd_register_1_i=3
//   -> same-cycle rd_data_1_o=0x12345678 (BYPASS=1); old value 0x0 (BYPASS=0).
// 4 issue r7
//   -> next cycle rd_busy_1_o=1 (rd 7), count=1.
//   -> write r7=0xA5: rd_busy_1_o=0 and data 0xA5 same cycle; count=0 next cycle.
// 5 issue r9; next cycle issue r9 + write r9=0x1 together -> busy r9 stays 1, count stays 1, rd r9=0x1 after.
// 6 issue r4 two consecutive cycles -> issue_conflict_o=1 exactly one cycle after the second issue, count=1.

Source files
------------

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with optional write-to-read bypass and a
// per-register busy scoreboard: destinations are reserved at issue and released at writeback.
module register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] rd_register_1_i,
  input  logic [ADDR_WIDTH-1:0] rd_register_2_i,
  output logic [DATA_WIDTH-1:0] rd_data_1_o,
  output logic [DATA_WIDTH-1:0] rd_data_2_o,
  output logic                  rd_busy_1_o,
  output logic                  rd_busy_2_o,
  input  logic                  reg_write_i,
  input  logic [ADDR_WIDTH-1:0] wr_register_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  issue_i,
  input  logic [ADDR_WIDTH-1:0] issue_register_i,
  output logic [ADDR_WIDTH:0]   pending_count_o,
  output logic                  issue_conflict_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_conflict;

  logic                  w_wr_legal;
  logic                  w_iss_legal;
  logic                  w_same_idx;
  logic                  w_inc;
  logic                  w_dec;
  logic                  w_conflict;
  logic [DEPTH-1:0]      w_busy_next;
  logic [ADDR_WIDTH:0]   w_count_next;

  assign w_wr_legal  = reg_write_i && !((ZERO_REG != 0) && (wr_register_i == '0));
  assign w_iss_legal = issue_i && !((ZERO_REG != 0) && (issue_register_i == '0));
  assign w_same_idx  = (wr_register_i == issue_register_i);

  // A same-index issue re-reserves the register, so the writeback's clear never lands.
  assign w_inc      = w_iss_legal && !r_busy[issue_register_i];
  assign w_dec      = w_wr_legal && r_busy[wr_register_i] && !(w_iss_legal && w_same_idx);
  assign w_conflict = w_iss_legal && r_busy[issue_register_i] && !(w_wr_legal && w_same_idx);

  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_legal)  w_busy_next[wr_register_i]    = 1'b0;
    if (w_iss_legal) w_busy_next[issue_register_i] = 1'b1;
  end

  always_comb begin
    w_count_next = r_count;
    if (w_inc && !w_dec)      w_count_next = r_count + 1'b1;
    else if (w_dec && !w_inc) w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy     <= '0;
      r_count    <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_wr_legal) r_regs[wr_register_i] <= wr_data_i;
      r_busy     <= w_busy_next;
      r_count    <= w_count_next;
      r_conflict <= w_conflict;
    end
  end

  always_comb begin
    rd_data_1_o = r_regs[rd_register_1_i];
    rd_busy_1_o = r_busy[rd_register_1_i];
    if ((BYPASS != 0) && w_wr_legal && (wr_register_i == rd_register_1_i)) begin
      rd_data_1_o = wr_data_i;
      rd_busy_1_o = 1'b0;
    end
    if ((ZERO_REG != 0) && (rd_register_1_i == '0)) begin
      rd_data_1_o = '0;
      rd_busy_1_o = 1'b0;
    end
  end

  always_comb begin
    rd_data_2_o = r_regs[rd_register_2_i];
    rd_busy_2_o = r_busy[rd_register_2_i];
    if ((BYPASS != 0) && w_wr_legal && (wr_register_i == rd_register_2_i)) begin
      rd_data_2_o = wr_data_i;
      rd_busy_2_o = 1'b0;
    end
    if ((ZERO_REG != 0) && (rd_register_2_i == '0)) begin
      rd_data_2_o = '0;
      rd_busy_2_o = 1'b0;
    end
  end

  assign pending_count_o  = r_count;
  assign issue_conflict_o = r_conflict;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb (default parameters: zero register, bypass on).
// Inputs change on the falling edge; registered outputs are checked on the falling edge.
module tb_register_file_sb;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [4:0]  rd_register_1_i, rd_register_2_i;
  logic [31:0] rd_data_1_o, rd_data_2_o;
  logic        rd_busy_1_o, rd_busy_2_o;
  logic        reg_write_i;
  logic [4:0]  wr_register_i;
  logic [31:0] wr_data_i;
  logic        issue_i;
  logic [4:0]  issue_register_i;
  logic [5:0]  pending_count_o;
  logic        issue_conflict_o;

  int n_pass = 0;
  int n_total = 0;

  register_file_sb dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .rd_register_1_i  (rd_register_1_i),
    .rd_register_2_i  (rd_register_2_i),
    .rd_data_1_o      (rd_data_1_o),
    .rd_data_2_o      (rd_data_2_o),
    .rd_busy_1_o      (rd_busy_1_o),
    .rd_busy_2_o      (rd_busy_2_o),
    .reg_write_i      (reg_write_i),
    .wr_register_i    (wr_register_i),
    .wr_data_i        (wr_data_i),
    .issue_i          (issue_i),
    .issue_register_i (issue_register_i),
    .pending_count_o  (pending_count_o),
    .issue_conflict_o (issue_conflict_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic cycle();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic idle();
    reset_i          = 1'b0;
    reg_write_i      = 1'b0;
    wr_register_i    = '0;
    wr_data_i        = '0;
    issue_i          = 1'b0;
    issue_register_i = '0;
  endtask

  task automatic test_reset();
    idle();
    rd_register_1_i = 5'd5;
    rd_register_2_i = 5'd6;
    reset_i = 1'b1;
    cycle();
    cycle();
    idle();
    #1;
    n_total++;
    if (rd_data_1_o !== 32'h0) $display("FAIL reset_init_data got=%h exp=%h", rd_data_1_o, 32'h0);
    else n_pass++;
    n_total++;
    if (pending_count_o !== 6'd0) $display("FAIL reset_init_count got=%0d exp=0", pending_count_o);
    else n_pass++;
    reg_write_i = 1'b1; wr_register_i = 5'd5; wr_data_i = 32'hDEADBEEF;
    issue_i = 1'b1; issue_register_i = 5'd6;
    cycle();
    idle();
    #1;
    n_total++;
    if (rd_data_1_o !== 32'hDEADBEEF) $display("FAIL pre_reset_r5 got=%h exp=%h", rd_data_1_o, 32'hDEADBEEF);
    else n_pass++;
    n_total++;
    if (rd_busy_2_o !== 1'b1 || pending_count_o !== 6'd1)
      $display("FAIL pre_reset_busy got=%b/%0d exp=1/1", rd_busy_2_o, pending_count_o);
    else n_pass++;
    reset_i = 1'b1;
    cycle();
    idle();
    #1;
    n_total++;
    if (rd_data_1_o !== 32'h0) $display("FAIL reset_r5 got=%h exp=%h", rd_data_1_o, 32'h0);
    else n_pass++;
    n_total++;
    if (rd_busy_2_o !== 1'b0) $display("FAIL reset_busy_r6 got=%b exp=0", rd_busy_2_o);
    else n_pass++;
    n_total++;
    if (pending_count_o !== 6'd0 || issue_conflict_o !== 1'b0)
      $display("FAIL reset_count_conf got=%0d/%b exp=0/0", pending_count_o, issue_conflict_o);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    idle();
    rd_register_1_i = 5'd0;
    reg_write_i = 1'b1; wr_register_i = 5'd0; wr_data_i = 32'hFFFFFFFF;
    issue_i = 1'b1; issue_register_i = 5'd0;
    #1;
    n_total++;
    if (rd_data_1_o !== 32'h0) $display("FAIL zero_bypass got=%h exp=%h", rd_data_1_o, 32'h0);
    else n_pass++;
    cycle();
    idle();
    #1;
    n_total++;
    if (rd_data_1_o !== 32'h0 || rd_busy_1_o !== 1'b0)
      $display("FAIL zero_reg got=%h/%b exp=0/0", rd_data_1_o, rd_busy_1_o);
    else n_pass++;
    n_total++;
    if (pending_count_o !== 6'd0 || issue_conflict_o !== 1'b0)
      $display("FAIL zero_count got=%0d/%b exp=0/0", pending_count_o, issue_conflict_o);
    else n_pass++;
  endtask

  task automatic test_bypass();
    idle();
    rd_register_1_i = 5'd3;
    rd_register_2_i = 5'd4;
    reg_write_i = 1'b1; wr_register_i = 5'd3; wr_data_i = 32'h12345678;
    #1;
    n_total++;
    if (rd_data_1_o !== 32'h12345678) $display("FAIL bypass_same_cycle got=%h exp=%h", rd_data_1_o, 32'h12345678);
    else n_pass++;
    n_total++;
    if (rd_data_2_o !== 32'h0) $display("FAIL bypass_other_port got=%h exp=%h", rd_data_2_o, 32'h0);
    else n_pass++;
    cycle();
    idle();
    rd_register_2_i = 5'd3;
    #1;
    n_total++;
    if (rd_data_1_o !== 32'h12345678 || rd_data_2_o !== 32'h12345678)
      $display("FAIL bypass_stored got=%h/%h exp=%h", rd_data_1_o, rd_data_2_o, 32'h12345678);
    else n_pass++;
  endtask

  task automatic test_issue_write();
    idle();
    rd_register_1_i = 5'd7;
    issue_i = 1'b1; issue_register_i = 5'd7;
    #1;
    n_total++;
    if (rd_busy_1_o !== 1'b0) $display("FAIL issue_latency got=%b exp=0", rd_busy_1_o);
    else n_pass++;
    cycle();
    idle();
    #1;
    n_total++;
    if (rd_busy_1_o !== 1'b1 || pending_count_o !== 6'd1)
      $display("FAIL issue_r7 got=%b/%0d exp=1/1", rd_busy_1_o, pending_count_o);
    else n_pass++;
    reg_write_i = 1'b1; wr_register_i = 5'd7; wr_data_i = 32'hA5;
    #1;
    n_total++;
    if (rd_busy_1_o !== 1'b0 || rd_data_1_o !== 32'hA5)
      $display("FAIL wb_bypass_r7 got=%b/%h exp=0/%h", rd_busy_1_o, rd_data_1_o, 32'hA5);
    else n_pass++;
    n_total++;
    if (pending_count_o !== 6'd1) $display("FAIL wb_count_latency got=%0d exp=1", pending_count_o);
    else n_pass++;
    cycle();
    idle();
    #1;
    n_total++;
    if (pending_count_o !== 6'd0 || rd_busy_1_o !== 1'b0 || rd_data_1_o !== 32'hA5)
      $display("FAIL wb_r7 got=%0d/%b/%h exp=0/0/%h", pending_count_o, rd_busy_1_o, rd_data_1_o, 32'hA5);
    else n_pass++;
  endtask

  task automatic test_same_index();
    idle();
    rd_register_1_i = 5'd9;
    issue_i = 1'b1; issue_register_i = 5'd9;
    cycle();
    issue_i = 1'b1; issue_register_i = 5'd9;
    reg_write_i = 1'b1; wr_register_i = 5'd9; wr_data_i = 32'h1;
    cycle();
    idle();
    #1;
    n_total++;
    if (rd_busy_1_o !== 1'b1 || pending_count_o !== 6'd1)
      $display("FAIL same_idx_busy got=%b/%0d exp=1/1", rd_busy_1_o, pending_count_o);
    else n_pass++;
    n_total++;
    if (rd_data_1_o !== 32'h1 || issue_conflict_o !== 1'b0)
      $display("FAIL same_idx_data got=%h/%b exp=%h/0", rd_data_1_o, issue_conflict_o, 32'h1);
    else n_pass++;
    reg_write_i = 1'b1; wr_register_i = 5'd9; wr_data_i = 32'h2;
    cycle();
    idle();
    #1;
    n_total++;
    if (pending_count_o !== 6'd0 || rd_busy_1_o !== 1'b0)
      $display("FAIL same_idx_release got=%0d/%b exp=0/0", pending_count_o, rd_busy_1_o);
    else n_pass++;
  endtask

  task automatic test_conflict();
    idle();
    issue_i = 1'b1; issue_register_i = 5'd4;
    cycle();
    #1;
    n_total++;
    if (issue_conflict_o !== 1'b0 || pending_count_o !== 6'd1)
      $display("FAIL conflict_first got=%b/%0d exp=0/1", issue_conflict_o, pending_count_o);
    else n_pass++;
    cycle();
    idle();
    #1;
    n_total++;
    if (issue_conflict_o !== 1'b1 || pending_count_o !== 6'd1)
      $display("FAIL conflict_pulse got=%b/%0d exp=1/1", issue_conflict_o, pending_count_o);
    else n_pass++;
    cycle();
    #1;
    n_total++;
    if (issue_conflict_o !== 1'b0) $display("FAIL conflict_width got=%b exp=0", issue_conflict_o);
    else n_pass++;
    reg_write_i = 1'b1; wr_register_i = 5'd4; wr_data_i = 32'h4;
    cycle();
    idle();
  endtask

  task automatic test_diff_indices();
    idle();
    rd_register_1_i = 5'd10;
    rd_register_2_i = 5'd11;
    issue_i = 1'b1; issue_register_i = 5'd10;
    reg_write_i = 1'b1; wr_register_i = 5'd11; wr_data_i = 32'hCAFE0011;
    cycle();
    idle();
    #1;
    n_total++;
    if (rd_busy_1_o !== 1'b1 || rd_busy_2_o !== 1'b0 || rd_data_2_o !== 32'hCAFE0011)
      $display("FAIL diff_idx got=%b/%b/%h exp=1/0/%h", rd_busy_1_o, rd_busy_2_o, rd_data_2_o, 32'hCAFE0011);
    else n_pass++;
    n_total++;
    if (pending_count_o !== 6'd1) $display("FAIL diff_idx_count got=%0d exp=1", pending_count_o);
    else n_pass++;
    rd_register_2_i = 5'd12;
    issue_i = 1'b1; issue_register_i = 5'd12;
    reg_write_i = 1'b1; wr_register_i = 5'd10; wr_data_i = 32'h10;
    cycle();
    idle();
    #1;
    n_total++;
    if (rd_busy_1_o !== 1'b0 || rd_busy_2_o !== 1'b1 || pending_count_o !== 6'd1)
      $display("FAIL swap_busy got=%b/%b/%0d exp=0/1/1", rd_busy_1_o, rd_busy_2_o, pending_count_o);
    else n_pass++;
    issue_i = 1'b1; issue_register_i = 5'd13;
    cycle();
    issue_i = 1'b1; issue_register_i = 5'd14;
    cycle();
    idle();
    #1;
    n_total++;
    if (pending_count_o !== 6'd3) $display("FAIL count_three got=%0d exp=3", pending_count_o);
    else n_pass++;
  endtask

  initial begin
    rd_register_1_i = '0;
    rd_register_2_i = '0;
    idle();
    reset_i = 1'b1;
    @(negedge clock_i);
    test_reset();
    test_zero_reg();
    test_bypass();
    test_issue_write();
    test_same_index();
    test_conflict();
    test_diff_indices();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
